// File: rtl/delay_ram_scheduler.sv
// Chorus delay-line sequencer: on each codec sample strobe it writes one sample into a
// single-port delay RAM, then reads NTAPS delayed taps back in a fixed-latency sequence.
module delay_ram_scheduler #(
    parameter int AW    = 9,
    parameter int DW    = 16,
    parameter int NTAPS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                VALID,
    input  logic [DW-1:0]       sample_in,
    input  logic [NTAPS*AW-1:0] tap_delay,
    input  logic [NTAPS-1:0]    tap_en,
    input  logic                clr_overrun,
    output logic [AW-1:0]       ram_addr,
    output logic                ram_we,
    output logic [DW-1:0]       ram_wdata,
    input  logic [DW-1:0]       ram_rdata,
    output logic [NTAPS*DW-1:0] tap_out,
    output logic                taps_valid,
    output logic                busy,
    output logic                overrun
);

    typedef enum logic [2:0] {IDLE, WR, RD0, RD1, RD2, LAST, DONE} state_t;

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   FILL_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   FILL_MAX = {1'b1, {AW{1'b0}}};

    state_t                r_state, w_next;
    logic                  r_sync1, r_sync2, r_sync3, r_armed;
    logic [1:0]            r_warm;
    logic                  w_start;
    logic [DW-1:0]         r_sample;
    logic [NTAPS*AW-1:0]   r_delay;
    logic [NTAPS-1:0]      r_en;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW:0]           r_fill;
    logic                  r_overrun;
    logic [DW-1:0]         r_tap [NTAPS];
    logic [AW-1:0]         w_delay [NTAPS];
    logic [AW-1:0]         w_wp;
    logic [AW-1:0]         w_ram_addr;
    logic                  w_ram_we;
    logic [DW-1:0]         w_ram_wdata;
    logic                  w_cap;
    logic [1:0]            w_cap_idx;
    logic                  w_keep;

    // Arming waits until the synchronizer holds real data and has seen VALID low,
    // so a strobe held high across reset release never looks like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_warm  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= VALID;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_warm  <= {r_warm[0], 1'b1};
            if (r_warm[1] && !r_sync2)
                r_armed <= 1'b1;
        end
    end

    assign w_start = r_armed & r_sync2 & ~r_sync3;

    for (genvar g = 0; g < NTAPS; g++) begin : g_tap
        assign w_delay[g]            = r_delay[g*AW +: AW];
        assign tap_out[g*DW +: DW]   = r_tap[g];
    end

    // wr_ptr has already advanced past the written slot once the reads begin
    assign w_wp   = r_wr_ptr - PTR_ONE;
    assign w_keep = r_en[w_cap_idx] && ({1'b0, w_delay[w_cap_idx]} < r_fill);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        w_cap       = 1'b0;
        w_cap_idx   = 2'd0;
        case (r_state)
            IDLE: if (w_start) w_next = WR;
            WR: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_wr_ptr;
                w_ram_wdata = r_sample;
                w_next      = RD0;
            end
            RD0: begin
                w_ram_addr = w_wp - w_delay[0];
                w_next     = RD1;
            end
            RD1: begin
                w_ram_addr = w_wp - w_delay[1];
                w_cap      = 1'b1;
                w_cap_idx  = 2'd0;
                w_next     = RD2;
            end
            RD2: begin
                w_ram_addr = w_wp - w_delay[2];
                w_cap      = 1'b1;
                w_cap_idx  = 2'd1;
                w_next     = LAST;
            end
            LAST: begin
                w_cap     = 1'b1;
                w_cap_idx = 2'd2;
                w_next    = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample  <= '0;
            r_delay   <= '0;
            r_en      <= '0;
            r_wr_ptr  <= '0;
            r_fill    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_start && r_state == IDLE) begin
                r_sample <= sample_in;
                r_delay  <= tap_delay;
                r_en     <= tap_en;
            end
            if (r_state == WR) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (r_fill != FILL_MAX)
                    r_fill <= r_fill + FILL_ONE;
            end
            // a strobe arriving mid-sequence is dropped; setting beats clearing
            if (w_start && r_state != IDLE)
                r_overrun <= 1'b1;
            else if (clr_overrun)
                r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++)
                r_tap[i] <= '0;
        end else if (w_cap) begin
            r_tap[w_cap_idx] <= w_keep ? ram_rdata : '0;
        end
    end

    assign ram_addr   = w_ram_addr;
    assign ram_we     = w_ram_we;
    assign ram_wdata  = w_ram_wdata;
    assign taps_valid = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_delay_ram_scheduler.sv
// Directed bench for delay_ram_scheduler with a behavioural single-port RAM attached;
// each step drives one VALID strobe and compares against hand-computed values.
module tb_delay_ram_scheduler;

    localparam int NONE = -10;

    logic        clk;
    logic        rst;
    logic        VALID;
    logic [15:0] sample_in;
    logic [26:0] tap_delay;
    logic [2:0]  tap_en;
    logic        clr_overrun;
    logic [8:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [47:0] tap_out;
    logic        taps_valid;
    logic        busy;
    logic        overrun;

    int compared   = 0;
    int mismatched = 0;

    int          obsValidK;
    int          obsValidCnt;
    int          obsWeCnt;
    logic [8:0]  obsWrAddr;
    logic [15:0] obsWrData;
    logic [10:0] obsBusy;
    logic [79:0] obsSnap;
    int          heldCount;

    logic [15:0] mem [512];

    delay_ram_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .VALID       (VALID),
        .sample_in   (sample_in),
        .tap_delay   (tap_delay),
        .tap_en      (tap_en),
        .clr_overrun (clr_overrun),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .tap_out     (tap_out),
        .taps_valid  (taps_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears one cycle after the address
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        VALID = 1'b0;
        clr_overrun = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state",
                    80'({ram_we, ram_addr, ram_wdata, tap_out, taps_valid, busy, overrun}), 80'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One strobe plus ten observed cycles; k counts posedges after VALID is raised,
    // so D is k=2, WR is k=3 and DONE is k=8.
    task automatic applyStimulus(input logic [15:0] smp, input logic [26:0] dly, input logic [2:0] en,
                                 input int edgeK, input int clrK, input int rstK);
        sample_in   = smp;
        tap_delay   = dly;
        tap_en      = en;
        VALID       = 1'b1;
        obsValidK   = 0;
        obsValidCnt = 0;
        obsWeCnt    = 0;
        obsWrAddr   = '0;
        obsWrData   = '0;
        obsBusy     = '0;
        obsSnap     = '1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (taps_valid) begin
                obsValidCnt++;
                if (obsValidK == 0) obsValidK = k;
            end
            if (ram_we) begin
                obsWeCnt++;
                obsWrAddr = ram_addr;
                obsWrData = ram_wdata;
            end
            obsBusy[k] = busy;
            if (k == 1) VALID = 1'b0;
            if (k == edgeK) begin
                VALID     = 1'b1;
                sample_in = 16'hBEEF;
                tap_delay = {3{9'h155}};
            end
            if (k == edgeK + 1) VALID = 1'b0;
            if (k == clrK) clr_overrun = 1'b1;
            if (k == clrK + 1) clr_overrun = 1'b0;
            if (k == rstK) rst = 1'b1;
            if (k == rstK + 2) begin
                obsSnap = 80'({ram_we, ram_addr, ram_wdata, tap_out, taps_valid, busy, overrun});
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'hDEAD;
        sample_in = '0;
        tap_delay = '0;
        tap_en = '0;
        clr_overrun = 1'b0;

        // VALID held high through reset release must not start a sequence
        VALID = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        heldCount = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (busy || ram_we) heldCount++;
        end
        checkOutput("held_valid_no_start", 80'(heldCount), 80'd0);
        VALID = 1'b0;

        $display("[TB] first sample after reset");
        resetDut();
        applyStimulus(16'h1234, {9'd2, 9'd1, 9'd0}, 3'b111, NONE, NONE, NONE);
        checkOutput("s1_wr_addr", 80'(obsWrAddr), 80'd0);
        checkOutput("s1_wr_data", 80'(obsWrData), 80'h1234);
        checkOutput("s1_we_cnt", 80'(obsWeCnt), 80'd1);
        checkOutput("s1_valid_k", 80'(obsValidK), 80'd8);
        checkOutput("s1_valid_cnt", 80'(obsValidCnt), 80'd1);
        checkOutput("s1_busy", 80'(obsBusy), 80'h1F8);
        checkOutput("s1_taps", 80'(tap_out), 80'({16'd0, 16'd0, 16'h1234}));

        $display("[TB] 600 samples with wrap");
        resetDut();
        for (int n = 1; n <= 599; n++) begin
            applyStimulus(16'(n), 27'd0, 3'b001, NONE, NONE, NONE);
            if (n == 512) checkOutput("wrap_addr_511", 80'(obsWrAddr), 80'd511);
            if (n == 513) checkOutput("wrap_addr_0", 80'(obsWrAddr), 80'd0);
        end
        applyStimulus(16'd600, {9'd511, 9'd100, 9'd0}, 3'b111, NONE, NONE, NONE);
        checkOutput("s2_wr_addr", 80'(obsWrAddr), 80'd87);
        checkOutput("s2_taps", 80'(tap_out), 80'({16'd89, 16'd500, 16'd600}));
        checkOutput("s2_valid_k", 80'(obsValidK), 80'd8);

        $display("[TB] delay beyond fill");
        resetDut();
        for (int n = 1; n <= 10; n++) applyStimulus(16'(n), 27'd0, 3'b001, NONE, NONE, NONE);
        applyStimulus(16'd11, {9'd0, 9'd20, 9'd0}, 3'b111, NONE, NONE, NONE);
        checkOutput("fill11_taps", 80'(tap_out), 80'({16'd11, 16'd0, 16'd11}));
        for (int n = 12; n <= 19; n++) applyStimulus(16'(n), 27'd0, 3'b001, NONE, NONE, NONE);
        applyStimulus(16'd20, {9'd0, 9'd20, 9'd0}, 3'b111, NONE, NONE, NONE);
        checkOutput("fill20_taps", 80'(tap_out), 80'({16'd20, 16'd0, 16'd20}));
        applyStimulus(16'd21, {9'd0, 9'd20, 9'd0}, 3'b111, NONE, NONE, NONE);
        checkOutput("fill21_taps", 80'(tap_out), 80'({16'd21, 16'd1, 16'd21}));

        $display("[TB] partial tap enable");
        applyStimulus(16'd22, {9'd1, 9'd1, 9'd1}, 3'b010, NONE, NONE, NONE);
        checkOutput("en010_taps", 80'(tap_out), 80'({16'd0, 16'd21, 16'd0}));
        checkOutput("en010_valid_k", 80'(obsValidK), 80'd8);
        checkOutput("en010_busy", 80'(obsBusy), 80'h1F8);

        $display("[TB] overrun");
        applyStimulus(16'd23, 27'd0, 3'b111, 3, NONE, NONE);
        checkOutput("ovr_we_cnt", 80'(obsWeCnt), 80'd1);
        checkOutput("ovr_wr_addr", 80'(obsWrAddr), 80'd22);
        checkOutput("ovr_wr_data", 80'(obsWrData), 80'd23);
        checkOutput("ovr_taps", 80'(tap_out), 80'({16'd23, 16'd23, 16'd23}));
        checkOutput("ovr_valid_k", 80'(obsValidK), 80'd8);
        checkOutput("ovr_valid_cnt", 80'(obsValidCnt), 80'd1);
        checkOutput("ovr_flag", 80'(overrun), 80'd1);
        applyStimulus(16'd24, {9'd0, 9'd1, 9'd0}, 3'b111, NONE, NONE, NONE);
        checkOutput("after_ovr_addr", 80'(obsWrAddr), 80'd23);
        checkOutput("after_ovr_taps", 80'(tap_out), 80'({16'd24, 16'd23, 16'd24}));
        checkOutput("ovr_sticky", 80'(overrun), 80'd1);

        $display("[TB] clear versus set");
        applyStimulus(16'd25, 27'd0, 3'b111, 3, 5, NONE);
        checkOutput("set_beats_clr", 80'(overrun), 80'd1);
        clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        clr_overrun = 1'b0;
        checkOutput("clr_alone", 80'(overrun), 80'd0);

        $display("[TB] reset mid-sequence");
        applyStimulus(16'h5555, 27'd0, 3'b111, NONE, NONE, 5);
        checkOutput("midrst_valid_cnt", 80'(obsValidCnt), 80'd0);
        checkOutput("midrst_outputs", obsSnap, 80'd0);
        applyStimulus(16'h0A0A, 27'd0, 3'b111, NONE, NONE, NONE);
        checkOutput("midrst_next_addr", 80'(obsWrAddr), 80'd0);
        checkOutput("midrst_next_taps", 80'(tap_out), 80'({16'h0A0A, 16'h0A0A, 16'h0A0A}));
        checkOutput("midrst_next_valid_k", 80'(obsValidK), 80'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/delay_ram_scheduler.md
DELAY_RAM_SCHEDULER -- requirements
Module: delay_ram_scheduler

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- AW, 9, delay RAM address width (512 entries)
- DW, 16, sample width
- NTAPS, 3, number of read taps (chorus voices)
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  single system clock
- rst  in  1  synchronous active-high reset
- VALID  in  1  codec sample strobe, asynchronous to clk
- sample_in  in  DW  new mono sample (left+right sum)
- tap_delay  in  NTAPS*AW  per-tap delay in samples; tap i at bits [i*AW +: AW]
- tap_en  in  NTAPS  per-tap enable
- clr_overrun  in  1  clears the overrun flag
- ram_addr  out  AW  single-port delay RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid 1 cycle after address
- tap_out  out  NTAPS*DW  registered tap samples; tap i at bits [i*DW +: DW]
- taps_valid  out  1  one-cycle pulse when all of tap_out has updated
- busy  out  1  sequence in progress
- overrun  out  1  sticky flag: a sample was dropped
REQ-003 The block SHALL use one clock, clk, with a synchronous active-high reset, rst.

Function
REQ-004 VALID SHALL pass through a two-flop synchronizer. A rising edge on the synchronized VALID SHALL produce a one-cycle start pulse in cycle D.
REQ-005 In cycle D, when the block is idle, it SHALL latch sample_in, tap_delay and tap_en. Input changes after D SHALL NOT affect the sequence in progress.
REQ-006 The FSM states SHALL be IDLE, WR, RD0, RD1, RD2, LAST and DONE. The sequence SHALL be IDLE(D) -> WR(D+1) -> RD0(D+2) -> RD1(D+3) -> RD2(D+4) -> LAST(D+5) -> DONE(D+6) -> IDLE.
REQ-007 In WR: ram_we=1, ram_addr=wr_ptr, ram_wdata=latched sample. wr_ptr SHALL increment at the end of WR, wrapping from 511 to 0.
REQ-008 In RDi: ram_we=0 and ram_addr=(wp - delay_i) mod 2^AW, where wp is the address written in WR. A delay of 0 SHALL return the sample just written.
REQ-009 Tap i's ram_rdata SHALL be captured one cycle after RDi: tap0 in RD1, tap1 in RD2, tap2 in LAST. tap_out SHALL remain stable outside capture cycles.
REQ-010 The captured value SHALL be forced to 0 when the tap is disabled, or when delay_i >= fill. fill is the number of samples written so far, including the current one, and saturates at 512.
REQ-011 All taps SHALL be sequenced regardless of tap_en, so latency is fixed. taps_valid SHALL be 1 only in DONE, at D+6. busy SHALL be 1 in states WR through DONE.
REQ-012 A start pulse while not IDLE SHALL set overrun and drop that sample. wr_ptr, fill and the running sequence SHALL be unaffected.
REQ-013 clr_overrun SHALL clear overrun. If a new overrun occurs in the same cycle, the set SHALL win.
REQ-014 ram_we SHALL be 1 only in WR. No RAM access is required in IDLE or DONE; ram_addr is don't-care there but SHALL be driven to 0.

Reset
REQ-015 While rst=1 the block SHALL hold: FSM=IDLE, wr_ptr=0, fill=0, synchronizer flops=0, tap_out=0, taps_valid=0, busy=0, overrun=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-016 Reset asserted mid-sequence SHALL abort the sequence. No taps_valid pulse SHALL follow, and the next sequence SHALL write address 0.
REQ-017 A VALID edge seen by the synchronizer only after reset release SHALL start a sequence; VALID held high through reset release SHALL NOT.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset, one VALID edge, sample_in=0x1234, delays {0,1,2}, tap_en=3'b111 -> write at address 0; tap_out={0,0,0x1234}; taps_valid exactly at D+6.
- Write samples 1..600 (value = n), then delays {0,100,511} -> tap values equal 600, 500 and 89; ram_addr wraps 511 -> 0.
- Write 10 samples, then delay 20 on tap1 -> tap1 reads 0 while fill < 21.
- Second VALID edge at D+3 -> overrun=1; the sample is not written; wr_ptr advances by 1 only.
- clr_overrun asserted in the same cycle as a new overrun -> overrun stays 1; a later clr_overrun alone -> 0.
- rst asserted at D+3 -> no taps_valid; all outputs at reset values; the next sample writes address 0.
- tap_en=3'b010 -> tap0 and tap2 outputs are 0; latency is still D+6.
